// File: rtl/ram_arb_pkg.sv
// Shared types for the RAM port arbiter: FSM state encoding, requester IDs, default sizes.
package ram_arb_pkg;

    localparam int DEF_AW = 4;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_ACC  = 2'd1,
        ST_RD_RESP = 2'd2,
        ST_WR_ACC  = 2'd3
    } arb_state_e;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_id_e;

    function automatic req_id_e other_req(input req_id_e id);
        return (id == REQ_RD) ? REQ_WR : REQ_RD;
    endfunction

endpackage

// File: rtl/ram_arb_rr.sv
// Two-way round-robin pick: a lone requester wins; on contention the one that did not go last wins.
module ram_arb_rr
    import ram_arb_pkg::*;
(
    input  logic    i_rd_req,
    input  logic    i_wr_req,
    input  req_id_e i_last,
    output req_id_e o_winner,
    output logic    o_any
);

    // NOTE: every output gets a default before any branch, so no path leaves it unassigned (no latch).
    always_comb begin
        o_any    = i_rd_req | i_wr_req;
        o_winner = REQ_RD;
        if (i_rd_req && i_wr_req) begin
            o_winner = other_req(i_last);
        end else if (i_wr_req) begin
            o_winner = REQ_WR;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between a read and a write requester, one access in flight.
// Optional build macro RAM_ARB_LOCK_EN lets the current owner chain accesses via rd_lock/wr_lock.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_lock,
    output logic          rd_gnt,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_lock,
    output logic          wr_gnt,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          busy
);

    arb_state_e    r_state;
    arb_state_e    w_next_state;
    req_id_e       r_last;
    req_id_e       w_winner;
    logic          w_any;
    logic          w_rd_chain;
    logic          w_wr_chain;

    logic          r_rd_gnt;
    logic          r_rd_valid;
    logic [DW-1:0] r_rd_data;
    logic          r_wr_gnt;
    logic          r_ram_en;
    logic          r_ram_we;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    logic          r_busy;

`ifdef RAM_ARB_LOCK_EN
    assign w_rd_chain = rd_req & rd_lock;
    assign w_wr_chain = wr_req & wr_lock;
`else
    logic w_unused_lock;
    assign w_unused_lock = rd_lock ^ wr_lock;
    assign w_rd_chain    = 1'b0;
    assign w_wr_chain    = 1'b0;
`endif

    ram_arb_rr u_rr (
        .i_rd_req (rd_req),
        .i_wr_req (wr_req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next_state = (w_winner == REQ_RD) ? ST_RD_ACC : ST_WR_ACC;
                end
            end
            ST_RD_ACC:  w_next_state = ST_RD_RESP;
            ST_RD_RESP: w_next_state = w_rd_chain ? ST_RD_ACC : ST_IDLE;
            ST_WR_ACC:  w_next_state = w_wr_chain ? ST_WR_ACC : ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the state they describe;
    // the RAM answers during RD_RESP and rd_valid/rd_data appear on the following cycle.
    // NOTE: state and outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last      <= REQ_WR;
            r_rd_gnt    <= 1'b0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
            r_wr_gnt    <= 1'b0;
            r_ram_en    <= 1'b0;
            r_ram_we    <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_rd_gnt   <= (w_next_state == ST_RD_ACC);
            r_wr_gnt   <= (w_next_state == ST_WR_ACC);
            r_ram_en   <= (w_next_state == ST_RD_ACC) || (w_next_state == ST_WR_ACC);
            r_ram_we   <= (w_next_state == ST_WR_ACC);
            r_busy     <= (w_next_state != ST_IDLE);
            r_rd_valid <= (r_state == ST_RD_RESP);

            if (r_state == ST_RD_RESP) begin
                r_rd_data <= ram_rdata;
            end

            // Address/data are frozen when the access is granted; later requester changes are ignored.
            if (w_next_state == ST_RD_ACC) begin
                r_last     <= REQ_RD;
                r_ram_addr <= rd_addr;
            end else if (w_next_state == ST_WR_ACC) begin
                r_last      <= REQ_WR;
                r_ram_addr  <= wr_addr;
                r_ram_wdata <= wr_data;
            end
        end
    end

    assign rd_gnt    = r_rd_gnt;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;
    assign wr_gnt    = r_wr_gnt;
    assign ram_en    = r_ram_en;
    assign ram_we    = r_ram_we;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural single-port RAM and a random scoreboard phase.
// Lock chaining is exercised when RAM_ARB_LOCK_EN is defined; otherwise lock inputs must be ignored.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_lock;
    logic          rd_gnt;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_lock;
    logic          wr_gnt;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    always #5 clk = ~clk;

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_lock   (rd_lock),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_lock   (wr_lock),
        .wr_gnt    (wr_gnt),
        .ram_en    (ram_en),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .busy      (busy)
    );

    // Synchronous single-port RAM: read data valid the cycle after the read enable.
    logic [DW-1:0] ram     [16];
    logic [DW-1:0] exp_mem [16];

    always @(posedge clk) begin
        if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) ram_rdata <= ram[ram_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_gnt"},    rd_gnt,    0);
        check({tag, "_rd_valid"},  rd_valid,  0);
        check({tag, "_rd_data"},   rd_data,   0);
        check({tag, "_wr_gnt"},    wr_gnt,    0);
        check({tag, "_ram_en"},    ram_en,    0);
        check({tag, "_ram_we"},    ram_we,    0);
        check({tag, "_ram_addr"},  ram_addr,  0);
        check({tag, "_ram_wdata"}, ram_wdata, 0);
        check({tag, "_busy"},      busy,      0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rd_req = 1'b0; wr_req = 1'b0; rd_lock = 1'b0; wr_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Bounded waits: n counts negedges until the event, capped at 12.
    task automatic wait_gnt(input logic want_rd, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(want_rd ? rd_gnt : wr_gnt) && n < 12);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rd_valid && n < 12);
    endtask

    // Read from an idle port: gnt one cycle after request, data two cycles after gnt.
    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        int n;
        rd_req = 1'b1; rd_addr = a;
        wait_gnt(1'b1, n);
        check("rd_gnt_latency", n, 1);
        check("rd_issue_en", ram_en, 1);
        check("rd_issue_we", ram_we, 0);
        check("rd_issue_addr", ram_addr, a);
        rd_req = 1'b0;
        wait_valid(n);
        check("rd_valid_latency", n, 2);
        check("rd_data", rd_data, exp);
        @(negedge clk);
        check("rd_valid_pulse", rd_valid, 0);
        check("rd_data_hold", rd_data, exp);
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n;
        wr_req = 1'b1; wr_addr = a; wr_data = d;
        wait_gnt(1'b0, n);
        check("wr_gnt_latency", n, 1);
        check("wr_issue_en", ram_en, 1);
        check("wr_issue_we", ram_we, 1);
        check("wr_issue_addr", ram_addr, a);
        check("wr_issue_data", ram_wdata, d);
        wr_req = 1'b0;
        exp_mem[a] = d;
        @(negedge clk);
        check("wr_gnt_pulse", wr_gnt, 0);
        check("wr_we_pulse", ram_we, 0);
    endtask

    int  n;
    int  g;
    logic seen;
    int  rd_wait, wr_wait, n_rd_req, n_rd_gnt, n_wr_req, n_wr_gnt;
    logic rd_out;
    logic [DW-1:0] rd_exp;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            ram[i]     = 16'h1000 + 16'(i);
            exp_mem[i] = 16'h1000 + 16'(i);
        end
        ram[5] = 16'hA5A5; exp_mem[5] = 16'hA5A5;
        rd_addr = '0; wr_addr = '0; wr_data = '0;

        // Reset state
        rst = 1'b1; rd_req = 1'b0; wr_req = 1'b0; rd_lock = 1'b0; wr_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1: lone read
        do_read(4'd5, 16'hA5A5);

        // 2: lone write, then read it back
        do_write(4'd3, 16'h1234);
        do_read(4'd3, 16'h1234);

        // 3: both held, strict alternation starting with read after reset
        do_reset();
        rd_req = 1'b1; rd_addr = 4'd2;
        wr_req = 1'b1; wr_addr = 4'd4; wr_data = 16'h5555;
        g = 0;
        for (int c = 0; c < 60 && g < 6; c++) begin
            @(negedge clk);
            check("alt_both_gnt", rd_gnt & wr_gnt, 0);
            if (rd_gnt || wr_gnt) begin
                check($sformatf("alt_order_%0d", g), wr_gnt, g % 2);
                g++;
            end
        end
        check("alt_grant_count", g, 6);
        rd_req = 1'b0; wr_req = 1'b0;
        exp_mem[4] = 16'h5555;
        repeat (4) @(negedge clk);
        check("alt_idle", busy, 0);

        // 4: reset during RD_ACC discards the read
        rd_req = 1'b1; rd_addr = 4'd9;
        wait_gnt(1'b1, n);
        check("rst_mid_gnt", n, 1);
        rst = 1'b1; rd_req = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            seen = seen | rd_valid | rd_gnt;
        end
        check("rst_mid_no_valid", seen, 0);
        do_read(4'd3, 16'h1234);

        // 5: rd_lock with a competing write
        do_reset();
        rd_req = 1'b1; rd_lock = 1'b1; rd_addr = 4'd0;
        wr_req = 1'b1; wr_addr = 4'd7; wr_data = 16'hBEEF;
        wait_gnt(1'b1, n);
        check("lock_first_rd", n, 1);
        check("lock_first_addr", ram_addr, 0);
        rd_addr = 4'd1;
        @(negedge clk);
        check("lock_gap_rd_gnt", rd_gnt, 0);
        @(negedge clk);
        check("lock_valid0", rd_valid, 1);
        check("lock_data0", rd_data, 16'h1000);
        check("lock_no_wr_yet", wr_gnt, 0);
`ifdef RAM_ARB_LOCK_EN
        check("lock_chain_gnt", rd_gnt, 1);
        check("lock_chain_addr", ram_addr, 1);
        rd_req = 1'b0; rd_lock = 1'b0;
        wait_valid(n);
        check("lock_valid1_lat", n, 2);
        check("lock_data1", rd_data, 16'h1001);
        wait_gnt(1'b0, n);
        check("lock_then_wr", n, 1);
        check("lock_wr_addr", ram_addr, 7);
        check("lock_wr_data", ram_wdata, 16'hBEEF);
        wr_req = 1'b0;
        exp_mem[7] = 16'hBEEF;
`else
        check("nolock_rd_gnt", rd_gnt, 0);
        rd_lock = 1'b0;
        wait_gnt(1'b0, n);
        check("nolock_wr_next", n, 1);
        check("nolock_wr_addr", ram_addr, 7);
        check("nolock_wr_data", ram_wdata, 16'hBEEF);
        wr_req = 1'b0;
        exp_mem[7] = 16'hBEEF;
        wait_gnt(1'b1, n);
        check("nolock_rd_after", n, 2);
        check("nolock_rd_addr", ram_addr, 1);
        rd_req = 1'b0;
        wait_valid(n);
        check("nolock_data1", rd_data, 16'h1001);
`endif
        repeat (3) @(negedge clk);

        // 6: random requesters with scoreboard
        rd_out = 1'b0; rd_exp = '0;
        rd_wait = 0; wr_wait = 0;
        n_rd_req = 0; n_rd_gnt = 0; n_wr_req = 0; n_wr_gnt = 0;
        for (int c = 0; c < 10016; c++) begin
            @(negedge clk);
            check("we_implies_en", ram_we & ~ram_en, 0);
            check("gnt_exclusive", rd_gnt & wr_gnt, 0);
            if (rd_valid) begin
                check("rnd_valid_expected", rd_out, 1);
                check("rnd_rd_data", rd_data, rd_exp);
                rd_out = 1'b0;
            end
            if (rd_gnt) begin
                check("rnd_rd_gnt_req", rd_req, 1);
                check("rnd_rd_addr", ram_addr, rd_addr);
                check("rnd_rd_wait", rd_wait <= 3, 1);
                rd_exp = exp_mem[rd_addr];
                rd_out = 1'b1;
                rd_req = 1'b0;
                n_rd_gnt++;
            end else if (rd_req) begin
                rd_wait++;
            end else if (c < 10000 && $urandom_range(0, 3) == 0) begin
                rd_req = 1'b1; rd_addr = 4'($urandom_range(0, 15));
                rd_wait = 0; n_rd_req++;
            end
            if (wr_gnt) begin
                check("rnd_wr_gnt_req", wr_req, 1);
                check("rnd_wr_addr", ram_addr, wr_addr);
                check("rnd_wr_data", ram_wdata, wr_data);
                check("rnd_wr_wait", wr_wait <= 3, 1);
                exp_mem[wr_addr] = wr_data;
                wr_req = 1'b0;
                n_wr_gnt++;
            end else if (wr_req) begin
                wr_wait++;
            end else if (c < 10000 && $urandom_range(0, 3) == 0) begin
                wr_req = 1'b1; wr_addr = 4'($urandom_range(0, 15));
                wr_data = 16'($urandom);
                wr_wait = 0; n_wr_req++;
            end
        end
        check("rnd_rd_all_granted", n_rd_gnt, n_rd_req);
        check("rnd_wr_all_granted", n_wr_gnt, n_wr_req);
        check("rnd_rd_drained", rd_out, 0);
        check("rnd_rd_req_clear", rd_req, 0);
        check("rnd_wr_req_clear", wr_req, 0);
        check("rnd_final_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
